// File: rtl/operand_driver.sv
// Operand driver: flushes the DUT, measures its latency with a probe, then aligns delayed operands.
// Optional feature macro: OPERAND_DRIVER_TIMEOUT_EN enables the PROBE timeout and the TIMEOUT state.
module operand_driver #(
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned MAX_LAT = 15,
  localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic             clk_dut,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_rand_a,
  input  logic [WIDTH-1:0] i_rand_b,
  input  logic [WIDTH-1:0] i_dut_out,
  output logic [WIDTH-1:0] o_drive_a,
  output logic [WIDTH-1:0] o_drive_b,
  output logic [WIDTH-1:0] o_drive_delayed_a,
  output logic [WIDTH-1:0] o_drive_delayed_b,
  output logic             o_delayed_valid,
  output logic [LAT_W-1:0] o_lat,
  output logic             o_lat_valid,
  output logic             o_timeout
);

  typedef enum logic [1:0] {FLUSH, PROBE, RUN, TIMEOUT} state_e;

  localparam logic [LAT_W-1:0] CNT_MAX = LAT_W'(MAX_LAT);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             lat_valid_q, lat_valid_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] dly_a_q [1:MAX_LAT];
  logic [WIDTH-1:0] dly_b_q [1:MAX_LAT];
`ifdef OPERAND_DRIVER_TIMEOUT_EN
  logic             timeout_q, timeout_d;
`endif

  // State and measurement registers
  always_ff @(posedge clk_dut or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FLUSH;
      cnt_q       <= '0;
      lat_q       <= '0;
      lat_valid_q <= 1'b0;
      base_q      <= '0;
`ifdef OPERAND_DRIVER_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      lat_valid_q <= lat_valid_d;
      base_q      <= base_d;
`ifdef OPERAND_DRIVER_TIMEOUT_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Next-state and measurement logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    lat_valid_d = lat_valid_q;
    base_d      = base_q;
`ifdef OPERAND_DRIVER_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif
    case (state_q)
      FLUSH: begin
        if (cnt_q == CNT_MAX) begin
          base_d  = i_dut_out;
          cnt_d   = '0;
          state_d = PROBE;
        end else begin
          cnt_d = cnt_q + LAT_W'(1);
        end
      end
      PROBE: begin
        if (i_dut_out != base_q) begin
          lat_d       = cnt_q;
          lat_valid_d = 1'b1;
          state_d     = RUN;
        end else if (cnt_q == CNT_MAX) begin
`ifdef OPERAND_DRIVER_TIMEOUT_EN
          timeout_d   = 1'b1;
          lat_valid_d = 1'b0;
          state_d     = TIMEOUT;
`else
          // Saturate and keep waiting; a later change reports MAX_LAT
          cnt_d = cnt_q;
`endif
        end else begin
          cnt_d = cnt_q + LAT_W'(1);
        end
      end
      RUN, TIMEOUT: begin
        if (i_start) begin
          lat_d       = '0;
          lat_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = FLUSH;
`ifdef OPERAND_DRIVER_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  // Zero drive while flushing, live random operands otherwise
  always_comb begin
    o_drive_a = '0;
    o_drive_b = '0;
    if (state_q != FLUSH) begin
      o_drive_a = i_rand_a;
      o_drive_b = i_rand_b;
    end
  end

  // Delay line of driven operands, shifting every cycle
  always_ff @(posedge clk_dut or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= int'(MAX_LAT); k++) begin
        dly_a_q[k] <= '0;
        dly_b_q[k] <= '0;
      end
    end else begin
      dly_a_q[1] <= o_drive_a;
      dly_b_q[1] <= o_drive_b;
      for (int k = 2; k <= int'(MAX_LAT); k++) begin
        dly_a_q[k] <= dly_a_q[k-1];
        dly_b_q[k] <= dly_b_q[k-1];
      end
    end
  end

  // Tap select: tap 0 is the live drive
  always_comb begin
    o_drive_delayed_a = o_drive_a;
    o_drive_delayed_b = o_drive_b;
    for (int k = 1; k <= int'(MAX_LAT); k++) begin
      if (lat_q == LAT_W'(k)) begin
        o_drive_delayed_a = dly_a_q[k];
        o_drive_delayed_b = dly_b_q[k];
      end
    end
  end

  assign o_delayed_valid = (state_q == RUN);
  assign o_lat           = lat_q;
  assign o_lat_valid     = lat_valid_q;
`ifdef OPERAND_DRIVER_TIMEOUT_EN
  assign o_timeout       = timeout_q;
`else
  assign o_timeout       = 1'b0;
`endif

endmodule
